// File: rtl/ack_nak_gen.sv
// Data-link receive-side ACK/NAK DLLP scheduler: tracks next_rcv_seq, classifies
// received TLPs and requests ACK/NAK DLLPs. Define ACK_COALESCE_EN for timer-based ACK coalescing.
module ack_nak_gen #(
  parameter int unsigned ACK_LAT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tlp_valid,
  input  logic [11:0] tlp_seq,
  input  logic        lcrc_ok,
  input  logic        busy_n,
  output logic [1:0]  ack_nack,
  output logic [11:0] dllp_seq,
  output logic        tlp_accept,
  output logic        nak_sched
);

  localparam int unsigned SEQ_W   = 12;
  localparam int unsigned TIMER_W = 10;
  localparam int unsigned DUP_WIN = 2048;

  if (ACK_LAT < 2 || ACK_LAT > 1023) begin : g_bad_ack_lat
    $error("ack_nak_gen: ACK_LAT out of range 2..1023");
  end

  // Encoding doubles as the ack_nack request code
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACK_REQ = 2'b01,
    NAK_REQ = 2'b10
  } state_t;

  state_t             state, state_next;
  logic [SEQ_W-1:0]   next_rcv_seq;
  logic [SEQ_W-1:0]   seq_diff;
  logic               nak_pending;
  logic               ack_force;

  logic good_c, dup_c, bad_c, nak_event_c;
  logic xfer_c, ack_xfer_c, nak_xfer_c;
  logic ack_due_c, force_set_c;

  // Classify the incoming TLP against the expected sequence number (mod 4096)
  assign seq_diff    = next_rcv_seq - tlp_seq;
  assign good_c      = tlp_valid && lcrc_ok && (seq_diff == '0);
  assign dup_c       = tlp_valid && lcrc_ok && (seq_diff != '0) && (seq_diff <= SEQ_W'(DUP_WIN));
  assign bad_c       = tlp_valid && !good_c && !dup_c;
  assign nak_event_c = bad_c && !nak_sched;

  assign xfer_c     = (state != IDLE) && busy_n;
  assign ack_xfer_c = xfer_c && (state == ACK_REQ);
  assign nak_xfer_c = xfer_c && (state == NAK_REQ);

`ifdef ACK_COALESCE_EN
  logic               ack_pending;
  logic [TIMER_W-1:0] ack_timer;
  logic               timer_exp_c;

  assign timer_exp_c = ack_pending && (ack_timer == TIMER_W'(ACK_LAT - 1));
  assign ack_due_c   = ack_force || timer_exp_c;
  assign force_set_c = dup_c;

  // Coalescing timer runs only while an ACK is owed and nothing is being requested
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_pending <= 1'b0;
      ack_timer   <= '0;
    end else begin
      if (ack_xfer_c)
        ack_timer <= '0;
      else if (state == IDLE && ack_pending && !timer_exp_c)
        ack_timer <= ack_timer + TIMER_W'(1);

      if (good_c)
        ack_pending <= 1'b1;
      else if (ack_xfer_c)
        ack_pending <= 1'b0;
    end
  end
`else
  assign ack_due_c   = ack_force;
  assign force_set_c = dup_c || good_c;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NAK outranks ACK when leaving IDLE; requests hold until busy_n allows transfer
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (nak_pending)    state_next = NAK_REQ;
        else if (ack_due_c) state_next = ACK_REQ;
      end
      ACK_REQ, NAK_REQ: begin
        if (busy_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_rcv_seq <= '0;
      dllp_seq     <= '0;
      tlp_accept   <= 1'b0;
      nak_sched    <= 1'b0;
      nak_pending  <= 1'b0;
      ack_force    <= 1'b0;
    end else begin
      tlp_accept <= good_c;
      if (good_c) next_rcv_seq <= next_rcv_seq + SEQ_W'(1);

      if (good_c)           nak_sched <= 1'b0;
      else if (nak_event_c) nak_sched <= 1'b1;

      if (nak_event_c)     nak_pending <= 1'b1;
      else if (nak_xfer_c) nak_pending <= 1'b0;

      // A new reason to ACK in the transfer cycle must survive the clear
      if (force_set_c)     ack_force <= 1'b1;
      else if (ack_xfer_c) ack_force <= 1'b0;

      if (state == IDLE && state_next != IDLE)
        dllp_seq <= next_rcv_seq - SEQ_W'(1);
    end
  end

  assign ack_nack = 2'(state);

endmodule

// File: tb/tb_ack_nak_gen.sv
// Bench for ack_nak_gen: cycle model of the receive-side ACK/NAK rules plus directed scenarios.
module tb_ack_nak_gen;

  localparam int unsigned ACK_LAT = 64;
`ifdef ACK_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tlp_valid = 1'b0;
  logic [11:0] tlp_seq = '0;
  logic        lcrc_ok = 1'b0;
  logic        busy_n = 1'b1;
  logic [1:0]  ack_nack;
  logic [11:0] dllp_seq;
  logic        tlp_accept;
  logic        nak_sched;

  ack_nak_gen #(.ACK_LAT(ACK_LAT)) dut (
    .clk(clk), .reset(reset), .tlp_valid(tlp_valid), .tlp_seq(tlp_seq),
    .lcrc_ok(lcrc_ok), .busy_n(busy_n), .ack_nack(ack_nack), .dllp_seq(dllp_seq),
    .tlp_accept(tlp_accept), .nak_sched(nak_sched)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int acc_count = 0;
  int nak_cycles = 0;

  // Model state: what the receiver owes the link partner
  bit          live = 1'b0;
  int unsigned m_exp = 0;
  int unsigned m_req = 0;
  int unsigned m_dseq = 0;
  int unsigned m_wait = 0;
  bit          m_acc = 1'b0, m_nsched = 1'b0, m_nak_owed = 1'b0;
  bit          m_ack_owed = 1'b0, m_unacked = 1'b0;

  always @(posedge clk) begin
    int unsigned diff, old_req;
    bit good, dup, bad, ack_done, nak_done;
    if (reset) begin
      live = 1'b1;
      m_exp = 0; m_req = 0; m_dseq = 0; m_wait = 0;
      m_acc = 0; m_nsched = 0; m_nak_owed = 0; m_ack_owed = 0; m_unacked = 0;
    end else begin
      diff = (m_exp + 4096 - int'(tlp_seq)) % 4096;
      good = tlp_valid && lcrc_ok && diff == 0;
      dup  = tlp_valid && lcrc_ok && diff >= 1 && diff <= 2048;
      bad  = tlp_valid && !good && !dup;
      old_req  = m_req;
      ack_done = (m_req == 1) && busy_n;
      nak_done = (m_req == 2) && busy_n;

      if (old_req == 0) begin
        if (m_nak_owed) begin
          m_req = 2; m_dseq = (m_exp + 4095) % 4096;
        end else if (m_ack_owed || (COAL && m_unacked && m_wait == ACK_LAT - 1)) begin
          m_req = 1; m_dseq = (m_exp + 4095) % 4096;
        end
      end else if (busy_n) begin
        m_req = 0;
      end

      if (COAL) begin
        if (ack_done) m_wait = 0;
        else if (old_req == 0 && m_unacked && m_wait < ACK_LAT - 1) m_wait++;
      end

      if (good) m_unacked = 1; else if (ack_done) m_unacked = 0;
      if (dup || (!COAL && good)) m_ack_owed = 1; else if (ack_done) m_ack_owed = 0;
      if (bad && !m_nsched) m_nak_owed = 1; else if (nak_done) m_nak_owed = 0;
      if (good) m_nsched = 0; else if (bad) m_nsched = 1;
      m_acc = good;
      if (good) m_exp = (m_exp + 1) % 4096;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      checks++;
      if (ack_nack !== 2'(m_req) || dllp_seq !== 12'(m_dseq) ||
          tlp_accept !== m_acc || nak_sched !== m_nsched) begin
        failures++;
        $display("FAIL model_cmp t=%0t got an=%0d ds=%0d acc=%0b ns=%0b want an=%0d ds=%0d acc=%0b ns=%0b",
                 $time, ack_nack, dllp_seq, tlp_accept, nak_sched, m_req, m_dseq, m_acc, m_nsched);
      end
      if (tlp_accept) acc_count++;
      if (ack_nack == 2'b10) nak_cycles++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send(input int s, input bit ok);
    tlp_valid = 1'b1;
    tlp_seq   = 12'(s);
    lcrc_ok   = ok;
    cyc();
    tlp_valid = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic wait_req(input string name, input int kind, input int s, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (int'(ack_nack) == kind && int'(dllp_seq) == s) found = 1'b1;
      else cyc();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s got an=%0d ds=%0d want an=%0d ds=%0d within %0d cycles",
               name, ack_nack, dllp_seq, kind, s, budget);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tlp_valid = 1'b0; busy_n = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    int bad_hold;
    do_reset();
    chk("reset_ack_nack", int'(ack_nack), 0);
    chk("reset_dllp_seq", int'(dllp_seq), 0);
    chk("reset_accept", int'(tlp_accept), 0);
    chk("reset_nak_sched", int'(nak_sched), 0);

    // Three in-order TLPs, one ACK for seq 2
    acc_count = 0;
    send(0, 1);
    chk("accept_latency", int'(tlp_accept), 1);
    send(1, 1);
    send(2, 1);
    wait_req("ack_seq2", 1, 2, 200);
    idle(5);
    chk("accept_count3", acc_count, 3);

    // Bad LCRC: one NAK for 4095, second bad TLP gets none
    do_reset();
    send(0, 0);
    wait_req("nak_4095", 2, 4095, 4);
    chk("nak_sched_set", int'(nak_sched), 1);
    idle(4);
    nak_cycles = 0;
    send(0, 0);
    idle(10);
    chk("no_second_nak", nak_cycles, 0);
    chk("nak_sched_held", int'(nak_sched), 1);
    send(0, 1);
    chk("nak_sched_clear", int'(nak_sched), 0);

    // Duplicates at next_rcv_seq=5
    send(1, 1); send(2, 1); send(3, 1); send(4, 1);
    idle(80);
    acc_count = 0;
    send(3, 1);
    wait_req("dup_ack4", 1, 4, 4);
    idle(3);
    chk("dup_not_accepted", acc_count, 0);
    send(2053, 1);
    wait_req("dup_edge_2048", 1, 4, 4);
    idle(3);
    send(2052, 1);
    wait_req("ahead_2049_nak", 2, 4, 4);
    idle(3);
    chk("ahead_nak_sched", int'(nak_sched), 1);

    // Held ACK request under back-pressure
    busy_n = 1'b0;
    send(3, 1);
    wait_req("busy_ack", 1, 4, 4);
    bad_hold = 0;
    for (int i = 0; i < 20; i++) begin
      if (ack_nack != 2'b01 || dllp_seq != 12'd4) bad_hold++;
      cyc();
    end
    chk("busy_hold_20", bad_hold, 0);
    busy_n = 1'b1;
    cyc();
    chk("busy_release", int'(ack_nack), 0);

    // Sequence wrap 4095 -> 0
    do_reset();
    acc_count = 0;
    for (int s = 0; s < 4096; s++) send(s, 1);
    send(0, 1);
    chk("wrap_accept0", int'(tlp_accept), 1);
    wait_req("wrap_ack0", 1, 0, 200);
    idle(5);
    chk("wrap_accept_count", acc_count, 4097);

    // Reset mid-handshake with NAK held
    do_reset();
    busy_n = 1'b0;
    send(0, 0);
    wait_req("held_nak", 2, 4095, 4);
    idle(3);
    chk("nak_still_held", int'(ack_nack), 2);
    reset = 1'b1; tlp_valid = 1'b1; tlp_seq = 12'd0; lcrc_ok = 1'b1;
    cyc();
    chk("rst_drop_ack_nack", int'(ack_nack), 0);
    chk("rst_drop_nak_sched", int'(nak_sched), 0);
    reset = 1'b0; tlp_valid = 1'b0; busy_n = 1'b1;
    cyc();
    chk("rst_tlp_ignored", int'(tlp_accept), 0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ack_nak_gen.md
ACK_NAK_GEN -- requirements
Module: ack_nak_gen

Interface
REQ-001 Parameter ACK_LAT, 64, ACK coalescing latency in clk cycles (range 2..1023).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tlp_valid  input  1  one received TLP's check results present this cycle.
REQ-005 tlp_seq  input  12  sequence number of received TLP.
REQ-006 lcrc_ok  input  1  received TLP passed LCRC check.
REQ-007 busy_n  input  1  DLLP transmit path ready (low = busy).
REQ-008 ack_nack  output  2  DLLP request: 00 none, 01 ACK, 10 NAK; 11 never driven.
REQ-009 dllp_seq  output  12  AckNak_Seq_Num carried with the ack_nack request.
REQ-010 tlp_accept  output  1  one-cycle pulse: TLP forwarded to transaction layer.
REQ-011 nak_sched  output  1  NAK_SCHEDULED flag.

Function
REQ-012 Block SHALL hold 12-bit next_rcv_seq; all sequence arithmetic modulo 4096 (4095+1 = 0).
REQ-013 tlp_valid, lcrc_ok=0: discard; if nak_sched=0, set nak_sched and nak_pending; if nak_sched=1, no action.
REQ-014 tlp_valid, lcrc_ok=1, tlp_seq == next_rcv_seq: tlp_accept=1 next cycle, next_rcv_seq+1, nak_sched cleared, ack_pending set.
REQ-015 tlp_valid, lcrc_ok=1, (next_rcv_seq - tlp_seq) mod 4096 in 1..2048 (duplicate): discard, set ack_force.
REQ-016 tlp_valid, lcrc_ok=1, any other tlp_seq (ahead): discard, treated as REQ-013.
REQ-017 Coalescing timer SHALL count while ack_pending=1 and state IDLE; at ACK_LAT-1 it requests ACK; reset to 0 on ACK transfer.
REQ-018 FSM states IDLE, ACK_REQ, NAK_REQ; ack_nack = 00/01/10 respectively, registered.
REQ-019 IDLE -> NAK_REQ when nak_pending=1 (priority over ACK); IDLE -> ACK_REQ when ack_force=1 or timer expired.
REQ-020 On entry to ACK_REQ/NAK_REQ, dllp_seq SHALL latch next_rcv_seq-1 and stay stable until transfer.
REQ-021 Transfer occurs in the cycle ack_nack != 00 and busy_n=1; next cycle state IDLE, ack_nack=00.
REQ-022 Requests SHALL be held indefinitely while busy_n=0; TLP processing continues meanwhile.
REQ-023 ACK transfer clears ack_pending and ack_force, except a TLP accepted in the same cycle re-sets ack_pending.
REQ-024 NAK transfer clears nak_pending only; nak_sched remains until next in-order good TLP.
REQ-025 NAK event arriving during ACK_REQ SHALL set nak_pending, served after ACK transfer (minimum one IDLE cycle).
REQ-026 Accepted TLP latency: tlp_accept asserted exactly 1 cycle after tlp_valid.

Reset
REQ-027 reset=1 at clk edge: next_rcv_seq=0, state IDLE, ack_nack=00, dllp_seq=0, tlp_accept=0, nak_sched=0, all pending flags and timer 0.
REQ-028 Reset mid-handshake SHALL drop ack_nack to 00 on that edge regardless of busy_n; tlp_valid during reset ignored.

Configuration
REQ-029 Macro ACK_COALESCE_EN defined: ACK coalescing per REQ-017.
REQ-030 ACK_COALESCE_EN undefined: timer absent, ACK_LAT ignored, every accepted TLP sets ack_force (immediate ACK).

Verification
REQ-031 Reset, good TLPs seq 0,1,2 back-to-back, busy_n=1 -> tlp_accept x3, one ACK with dllp_seq=2 after ACK_LAT cycles (coalesce on).
REQ-032 TLP seq 0 with lcrc_ok=0 -> nak_sched=1, ack_nack=10, dllp_seq=4095; second bad TLP -> no further NAK.
REQ-033 next_rcv_seq=5, good TLP seq 3 -> no tlp_accept, immediate ACK dllp_seq=4.
REQ-034 busy_n=0 for 20 cycles during ACK_REQ -> ack_nack=01 and dllp_seq stable 20 cycles, cleared 1 cycle after busy_n=1.
REQ-035 next_rcv_seq=4095, good TLP seq 4095 -> next_rcv_seq=0; following good seq 0 accepted, ACK dllp_seq=0.
REQ-036 Assert reset while ack_nack=10, busy_n=0 -> next cycle ack_nack=00, nak_sched=0.
